// File: rtl/disp_pkg.sv
// Shared constants, state type and bus helpers for the seven-segment
// display controllers.
package disp_pkg;

    localparam int unsigned DIGITS  = 6;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned BUS_W   = 24;

    typedef enum logic [1:0] {
        IDLE,
        LOCK,
        OPEN
    } arb_state_t;

    function automatic int unsigned bus_offset(input int unsigned idx);
        return idx * BUS_W;
    endfunction

    function automatic int unsigned dp_offset(input int unsigned idx);
        return idx * DIGITS;
    endfunction

endpackage

// File: rtl/disp_rr_pick.sv
// Combinational round-robin finder: first set, non-excluded request
// searching upward from last_i+1, wrapping modulo NREQ.
module disp_rr_pick #(
    parameter int unsigned NREQ = 3,
    localparam int unsigned IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    input  logic [NREQ-1:0] excl_i,
    output logic            found_o,
    output logic [IW-1:0]   idx_o
);

    int unsigned cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(last_i) + k) % NREQ;
            if (!found_o && req_i[cand] && !excl_i[cand]) begin
                found_o = 1'b1;
                idx_o   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter with minimum ownership time sharing one six-digit
// seven-segment driver among NREQ requesters.
module seg_display_arbiter
    import disp_pkg::*;
#(
    parameter int unsigned NREQ        = 3,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter logic [3:0]  IDLE_DIGIT  = 4'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*24-1:0]  digits_in,
    input  logic [NREQ*6-1:0]   dp_in,
    output logic [NREQ-1:0]     gnt,
    output logic                busy,
    output logic [3:0]          data1,
    output logic [3:0]          data2,
    output logic [3:0]          data3,
    output logic [3:0]          data4,
    output logic [3:0]          data5,
    output logic [3:0]          data6,
    output logic [5:0]          dp
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    // Leaving LOCK on the edge where the counter reaches HOLD_CYCLES-1 makes
    // a contended owner keep the display exactly HOLD_CYCLES cycles.
    localparam logic [CW-1:0] LAST_LOCK =
        CW'((HOLD_CYCLES >= 2) ? HOLD_CYCLES - 2 : 0);
    localparam arb_state_t GRANT_ST = (HOLD_CYCLES <= 1) ? OPEN : LOCK;

    arb_state_t          state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [IW-1:0]       last_q, last_d;
    logic [BUS_W-1:0]    bus_q, bus_d;
    logic [DIGITS-1:0]   dp_q, dp_d;

    logic                pick_found;
    logic [IW-1:0]       pick_idx;
    logic                owner_req;
    logic                take;

    disp_rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .excl_i  (gnt_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign owner_req = |(req & gnt_q);
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        take    = 1'b0;
        case (state_q)
            IDLE: take = pick_found;
            LOCK: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_q >= LAST_LOCK) state_d = OPEN;
                end
            end
            OPEN: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else begin
                    take = pick_found;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
        if (take) begin
            state_d = GRANT_ST;
            gnt_d   = NREQ'(1) << pick_idx;
            last_d  = pick_idx;
            cnt_d   = '0;
        end
    end

    always_comb begin
        bus_d = {DIGITS{IDLE_DIGIT}};
        dp_d  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_d[i]) begin
                bus_d = digits_in[bus_offset(i) +: BUS_W];
                dp_d  = dp_in[dp_offset(i) +: DIGITS];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            last_q  <= IW'(NREQ - 1);
            bus_q   <= {DIGITS{IDLE_DIGIT}};
            dp_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            bus_q   <= bus_d;
            dp_q    <= dp_d;
        end
    end

    assign gnt   = gnt_q;
    assign busy  = |gnt_q;
    assign data1 = bus_q[ 3: 0];
    assign data2 = bus_q[ 7: 4];
    assign data3 = bus_q[11: 8];
    assign data4 = bus_q[15:12];
    assign data5 = bus_q[19:16];
    assign data6 = bus_q[23:20];
    assign dp    = dp_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed and randomized checks of seg_display_arbiter against an
// ownership-level reference model.
module tb_seg_display_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned HOLD = 4;
    localparam logic [3:0]  IDL  = 4'hF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*24-1:0] digits_in = '0;
    logic [NREQ*6-1:0] dp_in = '0;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic [3:0]        data1, data2, data3, data4, data5, data6;
    logic [5:0]        dp;

    int checks = 0;
    int errors = 0;

    seg_display_arbiter #(
        .NREQ        (NREQ),
        .HOLD_CYCLES (HOLD),
        .IDLE_DIGIT  (IDL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .gnt       (gnt),
        .busy      (busy),
        .data1     (data1),
        .data2     (data2),
        .data3     (data3),
        .data4     (data4),
        .data5     (data5),
        .data6     (data6),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the display and for how many cycles.
    int          m_owner = -1;
    int          m_held  = 0;
    int          m_last  = NREQ - 1;
    logic [23:0] m_bus   = {6{IDL}};
    logic [5:0]  m_dp    = '0;

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last, input int excl);
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last + k) % NREQ;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int p;
        if (rst) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = NREQ - 1;
        end else begin
            p = -1;
            if (m_owner < 0) begin
                p = rr_pick(req, m_last, -1);
            end else if (!req[m_owner]) begin
                m_owner = -1;
            end else if (m_held >= HOLD) begin
                p = rr_pick(req, m_last, m_owner);
            end
            if (p >= 0) begin
                m_owner = p;
                m_last  = p;
                m_held  = 1;
            end else if (m_owner >= 0) begin
                m_held++;
            end
        end
        if (m_owner >= 0) begin
            m_bus = digits_in[m_owner*24 +: 24];
            m_dp  = dp_in[m_owner*6 +: 6];
        end else begin
            m_bus = {6{IDL}};
            m_dp  = '0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            check("model_busy", 32'(busy), 32'(m_owner >= 0));
            check("model_data", 32'({data6, data5, data4, data3, data2, data1}), 32'(m_bus));
            check("model_dp", 32'(dp), 32'(m_dp));
        end
    end

    task automatic sample_gnt(input string name, input logic [NREQ-1:0] exp);
        @(negedge clk);
        check(name, 32'(gnt), 32'(exp));
    endtask

    initial begin
        digits_in = {24'hABCDEF, 24'h654321, 24'h987654};
        dp_in     = {6'b010101, 6'b101011, 6'b110011};

        // reset state
        repeat (2) @(negedge clk);
        check("reset_gnt", 32'(gnt), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_data1", 32'(data1), 32'(IDL));
        check("reset_data6", 32'(data6), 32'(IDL));
        check("reset_dp", 32'(dp), 0);
        rst = 1'b0;

        // single request from requester 1
        req = 3'b010;
        @(negedge clk);
        check("single_gnt", 32'(gnt), 32'b010);
        check("single_busy", 32'(busy), 1);
        check("single_data", 32'({data6, data5, data4, data3, data2, data1}), 32'h654321);
        check("single_dp", 32'(dp), 32'b101011);
        req = 3'b000;
        @(negedge clk);

        // early release by requester 0
        req = 3'b001;
        sample_gnt("early_c0", 3'b001);
        sample_gnt("early_c1", 3'b001);
        req = 3'b000;
        sample_gnt("early_rel", 3'b000);
        check("early_busy", 32'(busy), 0);
        check("early_data1", 32'(data1), 32'(IDL));
        check("early_dp", 32'(dp), 0);

        // preemption after the hold time, no idle gap
        req = 3'b001;
        sample_gnt("preempt_c0", 3'b001);
        req = 3'b101;
        sample_gnt("preempt_c1", 3'b001);
        sample_gnt("preempt_c2", 3'b001);
        sample_gnt("preempt_c3", 3'b001);
        sample_gnt("preempt_hand", 3'b100);
        req = 3'b000;
        sample_gnt("preempt_idle", 3'b000);

        // round-robin fairness with all requests held
        req = 3'b111;
        for (int k = 0; k <= 12; k++) begin
            logic [NREQ-1:0] e;
            e = 3'b001 << ((k / HOLD) % NREQ);
            sample_gnt("rr_seq", e);
        end
        req = 3'b000;
        sample_gnt("rr_idle", 3'b000);

        // release on the expiry edge with another request pending
        req = 3'b001;
        sample_gnt("coin_c0", 3'b001);
        req = 3'b011;
        sample_gnt("coin_c1", 3'b001);
        sample_gnt("coin_c2", 3'b001);
        req = 3'b010;
        sample_gnt("coin_gap", 3'b000);
        sample_gnt("coin_next", 3'b010);
        req = 3'b000;
        sample_gnt("coin_idle", 3'b000);

        // asynchronous reset between edges
        req = 3'b100;
        sample_gnt("areset_own", 3'b100);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("areset_gnt", 32'(gnt), 0);
        check("areset_busy", 32'(busy), 0);
        check("areset_data", 32'({data6, data5, data4, data3, data2, data1}), 32'h00FFFFFF);
        check("areset_dp", 32'(dp), 0);
        @(negedge clk);
        rst = 1'b0;
        req = 3'b111;
        sample_gnt("areset_first", 3'b001);
        req = 3'b000;
        @(negedge clk);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) req[$urandom_range(NREQ - 1)] ^= 1'b1;
            digits_in = {$urandom, $urandom, $urandom};
            dp_in     = 18'($urandom);
        end
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
